// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that pushes one nibble per clock through a single 4-bit CLA slice.
// Latency: N = WIDTH/4 cycles from operand accept to out_valid; the next accept can happen one cycle after the output handshake.
// Backpressure: in_ready is low outside IDLE. DONE holds sum/co/ovf stable until out_ready is seen.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready   operand handshake (dina, dinb, cin)
//   out_valid / out_ready result handshake (sum, co, ovf)
//   sum                   A+B+cin modulo 2^WIDTH
//   co                    carry out of the MSB
//   ovf                   two's-complement overflow when NIBBLE_ADD_OVF_EN is defined, otherwise tied 0
//
// Build option: define NIBBLE_ADD_OVF_EN to build the overflow flag.

// 4-bit carry-lookahead slice: o_s = i_a + i_b + i_ci, with carry out o_co.
module full_adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // All carries are flattened sums of products, so no carry ripples inside the slice.
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_co = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  // Output copies, so sum/co hold their last result while the next
  // operation rebuilds r_sum/r_carry during RUN.
  logic [WIDTH-1:0] r_sum_out;
  logic             r_co_out;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s_nib;
  logic             w_co_nib;
  logic [WIDTH-1:0] w_sum_merged;
  logic             w_accept;
  logic             w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_idx == IW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Nibble select feeding the slice
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[4*k +: 4];
        w_b_nib = r_b[4*k +: 4];
      end
    end
  end

  full_adder4 u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_s_nib),
    .o_co (w_co_nib)
  );

  // r_sum with the current slice result dropped into nibble r_idx.
  // Kept in its own block so the slice loop stays acyclic.
  always_comb begin
    w_sum_merged = r_sum;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_sum_merged[4*k +: 4] = w_s_nib;
      end
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_sum_out <= '0;
      r_co_out  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= dina;
      r_b     <= dinb;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_merged;
      r_carry <= w_co_nib;
      if (w_last) begin
        r_sum_out <= w_sum_merged;
        r_co_out  <= w_co_nib;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum = r_sum_out;
  assign co  = r_co_out;

`ifdef NIBBLE_ADD_OVF_EN
  logic r_ovf;

  // On the final RUN edge the slice is processing the top nibble, so
  // w_s_nib[3] is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_s_nib[3] != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: instances at WIDTH = 4, 8 and 16 (index 0, 1, 2).
// Expected results come from an (A+B+cin) reference and are queued at accept, then checked at the output.
// Checks cover the reset state, directed sums, latency, backpressure stall, reset mid-run and a random sweep.
module tb_nibble_serial_adder;

`ifdef NIBBLE_ADD_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      in_valid;
  logic [2:0]      in_ready;
  logic [2:0]      out_valid;
  logic [2:0]      out_ready;
  logic [2:0]      cin;
  logic [2:0]      co;
  logic [2:0]      ovf;
  logic [2:0][15:0] dina;
  logic [2:0][15:0] dinb;
  logic [3:0]      sum4;
  logic [7:0]      sum8;
  logic [15:0]     sum16;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dina(dina[0][3:0]), .dinb(dinb[0][3:0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum4), .co(co[0]), .ovf(ovf[0])
  );

  nibble_serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dina(dina[1][7:0]), .dinb(dinb[1][7:0]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum8), .co(co[1]), .ovf(ovf[1])
  );

  nibble_serial_adder #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .dina(dina[2]), .dinb(dinb[2]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum16), .co(co[2]), .ovf(ovf[2])
  );

  function automatic logic [15:0] cur_sum(input int sel);
    case (sel)
      0:       return {12'h000, sum4};
      1:       return {8'h00, sum8};
      default: return sum16;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for in_ready, pass the accept edge, queue the reference result.
  // Entered and left #1 after a rising edge.
  task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b, input logic c);
    int          w;
    int          n;
    logic [15:0] mask;
    logic [15:0] am;
    logic [15:0] bm;
    logic [16:0] full;
    exp_t        e;
    w    = 4 << sel;
    n    = 0;
    mask = 16'((32'h1 << w) - 1);
    am   = a & mask;
    bm   = b & mask;
    dina[sel]     = am;
    dinb[sel]     = bm;
    cin[sel]      = c;
    in_valid[sel] = 1'b1;
    while (!in_ready[sel] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", 32'(in_ready[sel]), 32'd1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    chk("run_in_ready_low", 32'(in_ready[sel]), 32'd0);
    full  = {1'b0, am} + {1'b0, bm} + {16'h0000, c};
    e.sum = full[15:0] & mask;
    e.co  = full[w];
    e.ovf = OvfEn & (am[w-1] == bm[w-1]) & (e.sum[w-1] != am[w-1]);
    sb.push_back(e);
  endtask

  // Wait for out_valid, check latency and result, stall gap cycles, then hand shake.
  task automatic recv(input int sel, input int gap);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid[sel] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(1 << sel));
    e = sb.pop_front();
    chk("sum", 32'(cur_sum(sel)), 32'(e.sum));
    chk("co", 32'(co[sel]), 32'(e.co));
    chk("ovf", 32'(ovf[sel]), 32'(e.ovf));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid[sel]), 32'd1);
      chk("stall_in_ready", 32'(in_ready[sel]), 32'd0);
      chk("stall_sum", 32'(cur_sum(sel)), 32'(e.sum));
      chk("stall_co", 32'(co[sel]), 32'(e.co));
    end
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    chk("post_out_valid", 32'(out_valid[sel]), 32'd0);
    chk("post_in_ready", 32'(in_ready[sel]), 32'd1);
    chk("post_hold_sum", 32'(cur_sum(sel)), 32'(e.sum));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    cin       = '0;
    dina      = '0;
    dinb      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready[2]), 32'd1);
    chk("rst_out_valid", 32'(out_valid[2]), 32'd0);
    chk("rst_sum", 32'(sum16), 32'd0);
    chk("rst_co", 32'(co[2]), 32'd0);
    chk("rst_ovf", 32'(ovf[2]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sums, WIDTH = 16
    send(2, 16'h1234, 16'h4321, 1'b0); recv(2, 0);
    send(2, 16'hFFFF, 16'h0001, 1'b0); recv(2, 0);
    send(2, 16'hFFFF, 16'h0000, 1'b1); recv(2, 0);
    send(2, 16'h7FFF, 16'h0001, 1'b0); recv(2, 0);
    send(2, 16'h8000, 16'h8000, 1'b0); recv(2, 1);

    // Backpressure: 10 stalled cycles in DONE while new operands are offered
    send(2, 16'h1234, 16'h4321, 1'b0);
    dina[2]     = 16'h0AAA;
    dinb[2]     = 16'h0555;
    cin[2]      = 1'b0;
    in_valid[2] = 1'b1;
    recv(2, 10);
    send(2, 16'h0AAA, 16'h0555, 1'b0);
    recv(2, 0);

    // Reset during the second RUN cycle
    send(2, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_sum", 32'(sum16), 32'd0);
    chk("midrun_co", 32'(co[2]), 32'd0);
    chk("midrun_ovf", 32'(ovf[2]), 32'd0);
    chk("midrun_in_ready", 32'(in_ready[2]), 32'd1);
    chk("midrun_out_valid", 32'(out_valid[2]), 32'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2, 16'h0001, 16'h0001, 1'b0);
    recv(2, 0);

    // Random sweep with random out_ready gaps at each width
    for (int sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 15; i++) begin
        send(sel, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        recv(sel, int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
